// File: rtl/round_arbiter_if.sv
// ============================================================================
// Module      : round_arbiter_if
// Description : Request/result bundle between requesters, round_arbiter and
//               the downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface round_arbiter_if #(
  parameter int N_REQ        = 4,
  parameter int WIDTH_IN_MAX = 19,
  parameter int WIDTH_OUT    = 16,
  parameter int ID_W         = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
);
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ*WIDTH_IN_MAX-1:0] req_data;
  logic [N_REQ*8-1:0]            req_width;
  logic                          res_valid;
  logic                          res_ready;
  logic [WIDTH_OUT-1:0]          res_data;
  logic [ID_W-1:0]               res_id;
  logic                          res_err;

  // Requesters plus consumer side
  modport master (
    output req_valid, req_data, req_width, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_width, res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );
endinterface

`default_nettype wire

// File: rtl/round_arbiter.sv
// ============================================================================
// Module      : round_arbiter
// Description : Round-robin arbiter sharing one half-to-even rounder between
//               N_REQ requesters; 1-cycle latency, tagged valid/ready result.
//               Optional macro ROUND_ARB_PRIO0_EN gives requester 0 strict
//               priority over the round-robin group.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH_IN_MAX = 19,
  parameter int WIDTH_OUT    = 16,
  parameter int IS_SIGNED    = 1,
  parameter int ID_W         = ($clog2(N_REQ) < 1) ? 1 : $clog2(N_REQ)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  round_arbiter_if.slave    bus
);

  localparam int FRAC_W = WIDTH_IN_MAX - WIDTH_OUT;

`ifdef ROUND_ARB_PRIO0_EN
  localparam logic [N_REQ-1:0] RR_MASK = ~N_REQ'(1);
`else
  localparam logic [N_REQ-1:0] RR_MASK = '1;
`endif

  logic [ID_W-1:0]         r_ptr;
  logic                    r_res_valid;
  logic [ID_W-1:0]         r_res_id;
  logic                    r_res_err;
  logic [WIDTH_OUT-1:0]    r_dout;

  logic [N_REQ-1:0]        w_rr_req;
  logic                    w_hi_found;
  logic                    w_lo_found;
  logic [ID_W-1:0]         w_hi;
  logic [ID_W-1:0]         w_lo;
  logic                    w_found;
  logic                    w_is_prio;
  logic [ID_W-1:0]         w_gnt;
  logic                    w_can_issue;
  logic                    w_issue;
  logic [ID_W-1:0]         w_ptr_next;
  logic [WIDTH_IN_MAX-1:0] w_din;
  logic [7:0]              w_width;
  logic                    w_clamped;
  logic [7:0]              w_width_eff;
  logic [7:0]              w_shift;
  logic [WIDTH_IN_MAX-1:0] w_just;
  logic [WIDTH_OUT-1:0]    w_trunc;
  logic [WIDTH_OUT-1:0]    w_rounded;

  assign w_rr_req = bus.req_valid & RR_MASK;

  // Descending scan leaves the lowest index at/above ptr in w_hi and the
  // lowest index below ptr in w_lo; w_hi wins, w_lo covers the wrap.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rr_req[i]) begin
        if (ID_W'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi       = ID_W'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo       = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_found   = w_hi_found || w_lo_found;
    w_gnt     = w_hi_found ? w_hi : w_lo;
    w_is_prio = 1'b0;
`ifdef ROUND_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      w_found   = 1'b1;
      w_gnt     = '0;
      w_is_prio = 1'b1;
    end
`endif
  end

  // Reset gates issue so req_ready stays low while rst_n is held.
  assign w_can_issue   = rst_n && (!r_res_valid || bus.res_ready);
  assign w_issue       = w_can_issue && w_found;
  assign bus.req_ready = w_issue ? (N_REQ'(1) << w_gnt) : '0;
  assign w_ptr_next    = (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    w_din   = '0;
    w_width = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        w_din   = bus.req_data[i*WIDTH_IN_MAX +: WIDTH_IN_MAX];
        w_width = bus.req_width[i*8 +: 8];
      end
    end
  end

  assign w_clamped   = (w_width == 8'd0) || (w_width > 8'(WIDTH_IN_MAX));
  assign w_width_eff = w_clamped ? 8'(WIDTH_IN_MAX) : w_width;
  assign w_shift     = 8'(WIDTH_IN_MAX) - w_width_eff;
  assign w_just      = w_din << w_shift;
  assign w_trunc     = w_just[WIDTH_IN_MAX-1 -: WIDTH_OUT];

  generate
    if (FRAC_W > 0) begin : g_round
      localparam logic [FRAC_W-1:0] HALF = FRAC_W'(1) << (FRAC_W - 1);
      logic [FRAC_W-1:0]  w_frac;
      logic               w_inc;
      logic [WIDTH_OUT:0] w_sum;

      assign w_frac = w_just[FRAC_W-1:0];
      assign w_inc  = (w_frac > HALF) || ((w_frac == HALF) && w_trunc[0]);
      assign w_sum  = {1'b0, w_trunc} + {{WIDTH_OUT{1'b0}}, w_inc};

      // Rounding up can only overflow past the positive / unsigned maximum.
      always_comb begin
        w_rounded = w_sum[WIDTH_OUT-1:0];
        if (IS_SIGNED != 0) begin
          if (!w_trunc[WIDTH_OUT-1] && w_sum[WIDTH_OUT-1])
            w_rounded = {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end else if (w_sum[WIDTH_OUT]) begin
          w_rounded = '1;
        end
      end
    end else begin : g_exact
      assign w_rounded = w_trunc;
    end
  endgenerate

  // Rounder output register: no reset, holds while ena is low.
  always_ff @(posedge clk) begin
    if (w_issue)
      r_dout <= w_rounded;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_res_valid <= 1'b1;
        r_res_id    <= w_gnt;
        r_res_err   <= w_clamped;
        if (!w_is_prio)
          r_ptr <= w_ptr_next;
      end else if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_err   = r_res_err;
  assign bus.res_data  = r_res_valid ? r_dout : '0;

endmodule

`default_nettype wire
